noc_fifo_wr_arbiter: RTL

//  Round-robin, packet-locked arbiter sharing one FIFO write port among NREQ router

---
 rtl/noc_fifo_wr_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/noc_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : noc_fifo_wr_arbiter
//  Description : Round-robin, packet-locked (wormhole) arbiter that shares a
//                single async-FIFO write port among NREQ router requesters.
//                A grant is held from the first flit of a packet until its
//                last flit, or until MAX_PKT flits have been written, in
//                which case the packet is force-released and err_trunc
//                pulses for one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    wclk        in   1            write-domain clock, rising edge
//    wrst        in   1            synchronous reset, active-high
//    req_valid   in   NREQ         per-requester flit valid
//    req_data    in   NREQ*DSIZE   flits, requester i at [i*DSIZE +: DSIZE]
//    req_last    in   NREQ         flit is the last of its packet
//    req_ready   out  NREQ         flit accepted when valid & ready
//    fifo_wren   out  1            FIFO write enable
//    fifo_wdata  out  DSIZE        FIFO write data
//    fifo_wfull  in   1            FIFO full
//    gnt_id      out  clog2(NREQ)  current / most recent granted requester
//    busy        out  1            a packet is locked onto the write port
//    err_trunc   out  1            1-cycle pulse: packet force-released
// ============================================================================
module noc_fifo_wr_arbiter #(
    parameter int NREQ    = 4,
    parameter int DSIZE   = 8,
    parameter int MAX_PKT = 16
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      fifo_wren,
    output logic [DSIZE-1:0]          fifo_wdata,
    input  logic                      fifo_wfull,
    output logic [$clog2(NREQ)-1:0]   gnt_id,
    output logic                      busy,
    output logic                      err_trunc
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_PKT + 1);

    // Flit count reached when the transfer in flight is the MAX_PKT-th one.
    localparam logic [CW-1:0] c_cnt_last = CW'(MAX_PKT - 1);
    // After reset requester 0 is first in line.
    localparam logic [GW-1:0] c_rr_reset = GW'(NREQ - 1);
    localparam logic [GW-1:0] c_id_max   = GW'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_gnt_id;
    logic [GW-1:0]      w_gnt_nxt;
    logic [GW-1:0]      r_rr_ptr;
    logic [GW-1:0]      w_rr_nxt;
    logic [CW-1:0]      r_flit_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;

    logic [GW-1:0]      w_winner;
    logic               w_lock;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_xfer;
    logic [DSIZE-1:0]   w_data [NREQ];

    assign w_lock = (r_state == ST_LOCK);

    // ------------------------------------------------------------------------
    // Unpack the flat flit bus and build the per-requester ready bits. Ready
    // is withheld in the reset cycle so a requester never believes a flit was
    // taken while the packet is being abandoned.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            assign w_data[i]    = req_data[i*DSIZE +: DSIZE];
            assign req_ready[i] = w_lock && (r_gnt_id == GW'(i)) &&
                                  !fifo_wfull && !wrst;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin search: walk rr_ptr+1, rr_ptr+2, ... (wrapping at NREQ-1)
    // and take the first valid requester. The candidate index is stepped with
    // an explicit wrap so non-power-of-two NREQ works too.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [GW-1:0] cand;
        logic          found;
        w_winner = r_rr_ptr;
        cand     = r_rr_ptr;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == c_id_max) ? '0 : cand + GW'(1);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                w_winner = cand;
            end
        end
    end

    // Granted requester's handshake signals, valid only while locked.
    assign w_sel_valid = req_valid[r_gnt_id];
    assign w_sel_last  = req_last[r_gnt_id];
    assign w_xfer      = w_lock && w_sel_valid && !fifo_wfull && !wrst;

    assign fifo_wren   = w_xfer;
    assign fifo_wdata  = w_lock ? w_data[r_gnt_id] : '0;

    // ------------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_flit_cnt;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Arbitration cycle: no flit moves, the winner is locked in.
                if (|req_valid) begin
                    w_state_nxt = ST_LOCK;
                    w_gnt_nxt   = w_winner;
                    w_rr_nxt    = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCK: begin
                // Full FIFO or an idle requester simply freezes the packet.
                if (w_xfer) begin
                    w_cnt_nxt = r_flit_cnt + CW'(1);
                    if (w_sel_last) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_flit_cnt == c_cnt_last) begin
                        // Oversized packet: this flit is kept, the remainder
                        // re-arbitrates as if it were a fresh packet.
                        w_state_nxt = ST_IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_gnt_id   <= '0;
            r_rr_ptr   <= c_rr_reset;
            r_flit_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_gnt_id   <= w_gnt_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_flit_cnt <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign gnt_id    = r_gnt_id;
    assign busy      = w_lock;
    assign err_trunc = r_err;

endmodule
`default_nettype wire
